// File: rtl/gpr_writeback_stage.sv
// GPR write-back stage: selects ALU, load or link data and drives the register-file write port.
// Load ops whose data has not arrived park in WAIT_MEM until mem_rvalid.
module gpr_writeback_stage #(
  parameter  int unsigned DATA_W      = 32,
  parameter  int unsigned REG_ADDR_W  = 5,
  parameter  int unsigned LINK_OFFSET = 4,
  localparam int unsigned LANE_W      = $clog2(DATA_W / 8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sel,
  input  logic                  in_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic [1:0]            in_mem_size,
  input  logic                  in_mem_signed,
  input  logic [LANE_W-1:0]     in_addr_lo,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  gpr_we,
  output logic [REG_ADDR_W-1:0] gpr_waddr,
  output logic [DATA_W-1:0]     gpr_wdata,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_FULL = 2'b11;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic                    cap_we_q, cap_we_d;
  logic [REG_ADDR_W-1:0]   cap_rd_q, cap_rd_d;
  logic [1:0]              cap_size_q, cap_size_d;
  logic                    cap_signed_q, cap_signed_d;
  logic [LANE_W-1:0]       cap_lo_q, cap_lo_d;
  logic                    gpr_we_q, gpr_we_d;
  logic [REG_ADDR_W-1:0]   gpr_waddr_q, gpr_waddr_d;
  logic [DATA_W-1:0]       gpr_wdata_q, gpr_wdata_d;

  logic [1:0]              ext_size;
  logic                    ext_signed;
  logic [LANE_W-1:0]       ext_lo;
  logic [DATA_W-1:0]       load_data;
  logic [DATA_W-1:0]       link_data;

  // Align the addressed lane to bit 0, then sign- or zero-fill above the access width.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        size,
    input logic              sgn,
    input logic [LANE_W-1:0] lo
  );
    logic [LANE_W-1:0] lane;
    logic [LANE_W+2:0] shamt;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] res;
    int                nbits;
    logic              fill;
    case (size)
      SIZE_BYTE: begin lane = lo;                   nbits = 8;           end
      SIZE_HALF: begin lane = lo & ~LANE_W'(1);     nbits = 16;          end
      SIZE_WORD: begin lane = lo & ~LANE_W'(3);     nbits = 32;          end
      default:   begin lane = '0;                   nbits = int'(DATA_W); end
    endcase
    shamt   = {lane, 3'b000};
    shifted = raw >> shamt;
    fill    = sgn && (size != SIZE_FULL) && shifted[IDX_W'(nbits - 1)];
    for (int i = 0; i < int'(DATA_W); i++) begin
      res[i] = (i < nbits) ? shifted[i] : fill;
    end
    return res;
  endfunction

  // Load fields come from the captured op while waiting, else straight from the inputs.
  always_comb begin
    ext_size   = in_mem_size;
    ext_signed = in_mem_signed;
    ext_lo     = in_addr_lo;
    if (state_q == ST_WAIT_MEM) begin
      ext_size   = cap_size_q;
      ext_signed = cap_signed_q;
      ext_lo     = cap_lo_q;
    end
    load_data = load_extract(mem_rdata, ext_size, ext_signed, ext_lo);
    link_data = in_pc + DATA_W'(LINK_OFFSET);
  end

  // Next-state and write-port logic; waddr/wdata only move when a write fires.
  always_comb begin
    state_d      = state_q;
    cap_we_d     = cap_we_q;
    cap_rd_d     = cap_rd_q;
    cap_size_d   = cap_size_q;
    cap_signed_d = cap_signed_q;
    cap_lo_d     = cap_lo_q;
    gpr_we_d     = 1'b0;
    gpr_waddr_d  = gpr_waddr_q;
    gpr_wdata_d  = gpr_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          case (in_sel)
            SEL_ALU: begin
              if (in_we && (in_rd != '0)) begin
                gpr_we_d    = 1'b1;
                gpr_waddr_d = in_rd;
                gpr_wdata_d = in_alu;
              end
            end
            SEL_LINK: begin
              if (in_we && (in_rd != '0)) begin
                gpr_we_d    = 1'b1;
                gpr_waddr_d = in_rd;
                gpr_wdata_d = link_data;
              end
            end
            SEL_MEM: begin
              if (mem_rvalid) begin
                if (in_we && (in_rd != '0)) begin
                  gpr_we_d    = 1'b1;
                  gpr_waddr_d = in_rd;
                  gpr_wdata_d = load_data;
                end
              end else begin
                cap_we_d     = in_we;
                cap_rd_d     = in_rd;
                cap_size_d   = in_mem_size;
                cap_signed_d = in_mem_signed;
                cap_lo_d     = in_addr_lo;
                state_d      = ST_WAIT_MEM;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          if (cap_we_q && (cap_rd_q != '0)) begin
            gpr_we_d    = 1'b1;
            gpr_waddr_d = cap_rd_q;
            gpr_wdata_d = load_data;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, capture and write-port registers; reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cap_we_q     <= 1'b0;
      cap_rd_q     <= '0;
      cap_size_q   <= '0;
      cap_signed_q <= 1'b0;
      cap_lo_q     <= '0;
      gpr_we_q     <= 1'b0;
      gpr_waddr_q  <= '0;
      gpr_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cap_we_q     <= cap_we_d;
      cap_rd_q     <= cap_rd_d;
      cap_size_q   <= cap_size_d;
      cap_signed_q <= cap_signed_d;
      cap_lo_q     <= cap_lo_d;
      gpr_we_q     <= gpr_we_d;
      gpr_waddr_q  <= gpr_waddr_d;
      gpr_wdata_q  <= gpr_wdata_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_WAIT_MEM);
  assign gpr_we    = gpr_we_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;

endmodule

// File: tb/tb_gpr_writeback_stage.sv
// Directed bench for gpr_writeback_stage: 32-bit vector table, stall/reset sequences, 64-bit loads.
module tb_gpr_writeback_stage;

  logic clk;
  logic rst_n;

  // 32-bit instance signals
  logic        in_valid, in_ready, in_we, in_mem_signed, mem_rvalid;
  logic [1:0]  in_sel, in_mem_size;
  logic [4:0]  in_rd;
  logic [31:0] in_alu, in_pc, mem_rdata;
  logic [1:0]  in_addr_lo;
  logic        gpr_we, busy;
  logic [4:0]  gpr_waddr;
  logic [31:0] gpr_wdata;

  // 64-bit instance signals
  logic        w_valid, w_ready, w_we, w_signed, w_rvalid;
  logic [1:0]  w_sel, w_size;
  logic [4:0]  w_rd;
  logic [63:0] w_alu, w_pc, w_rdata;
  logic [2:0]  w_lo;
  logic        w_gpr_we, w_busy;
  logic [4:0]  w_waddr;
  logic [63:0] w_wdata;

  int n_checks;
  int n_fail;

  gpr_writeback_stage #(.DATA_W(32), .REG_ADDR_W(5), .LINK_OFFSET(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_we(in_we),
    .in_rd(in_rd), .in_alu(in_alu), .in_pc(in_pc), .in_mem_size(in_mem_size),
    .in_mem_signed(in_mem_signed), .in_addr_lo(in_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .busy(busy)
  );

  gpr_writeback_stage #(.DATA_W(64), .REG_ADDR_W(5), .LINK_OFFSET(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_valid), .in_ready(w_ready), .in_sel(w_sel), .in_we(w_we),
    .in_rd(w_rd), .in_alu(w_alu), .in_pc(w_pc), .in_mem_size(w_size),
    .in_mem_signed(w_signed), .in_addr_lo(w_lo),
    .mem_rvalid(w_rvalid), .mem_rdata(w_rdata),
    .gpr_we(w_gpr_we), .gpr_waddr(w_waddr), .gpr_wdata(w_wdata), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lo;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sel = 2'b11; in_we = 1'b0; in_rd = '0;
    in_alu = '0; in_pc = '0; in_mem_size = '0; in_mem_signed = 1'b0;
    in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // Issue a load that stalls three cycles before its data arrives.
  task automatic stalled_load(input logic [4:0] rd, input logic [1:0] size, input logic sgn,
                              input logic [1:0] lo, input logic [31:0] rdata,
                              input logic [31:0] exp, input string tag);
    in_valid = 1'b1; in_sel = 2'b01; in_we = 1'b1; in_rd = rd;
    in_mem_size = size; in_mem_signed = sgn; in_addr_lo = lo; mem_rvalid = 1'b0;
    chk({tag, "_ready_before"}, 64'(in_ready), 64'd1);
    tick();
    // A competing ALU op held on the inputs must not be taken while stalled.
    in_sel = 2'b00; in_rd = 5'd20; in_alu = 32'h1111_1111;
    for (int c = 0; c < 3; c++) begin
      chk({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_stall_busy"},  64'(busy),     64'd1);
      chk({tag, "_stall_we"},    64'(gpr_we),   64'd0);
      tick();
    end
    in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    chk({tag, "_we"},    64'(gpr_we),    64'd1);
    chk({tag, "_waddr"}, 64'(gpr_waddr), 64'(rd));
    chk({tag, "_wdata"}, 64'(gpr_wdata), 64'(exp));
    chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, "_busy_after"},  64'(busy),     64'd0);
    tick();
    chk({tag, "_we_drop"}, 64'(gpr_we), 64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            sel    we    rd     alu           pc            size   sgn   lo     rv    rdata         ewe   eaddr  edata
    vecs[0]  = '{2'b00, 1'b1, 5'd3,  32'h00C0FFEE, 32'h0,        2'b00, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 5'd3,  32'h00C0FFEE};
    vecs[1]  = '{2'b10, 1'b1, 5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 5'd5,  32'hDEADBEF3};
    vecs[2]  = '{2'b10, 1'b1, 5'd6,  32'h0,        32'hFFFFFFFE, 2'b00, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 5'd6,  32'h00000002};
    vecs[3]  = '{2'b00, 1'b1, 5'd0,  32'h12345678, 32'h0,        2'b00, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 5'd6,  32'h00000002};
    vecs[4]  = '{2'b11, 1'b1, 5'd7,  32'h0000AAAA, 32'h0,        2'b00, 1'b0, 2'd0, 1'b1, 32'h55555555, 1'b0, 5'd6,  32'h00000002};
    vecs[5]  = '{2'b00, 1'b0, 5'd8,  32'h87654321, 32'h0,        2'b00, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 5'd6,  32'h00000002};
    vecs[6]  = '{2'b01, 1'b1, 5'd9,  32'h0,        32'h0,        2'b00, 1'b1, 2'd1, 1'b1, 32'hBAADC0DE, 1'b1, 5'd9,  32'hFFFFFFC0};
    vecs[7]  = '{2'b01, 1'b1, 5'd10, 32'h0,        32'h0,        2'b01, 1'b1, 2'd3, 1'b1, 32'h8765F0A5, 1'b1, 5'd10, 32'hFFFF8765};
    vecs[8]  = '{2'b01, 1'b1, 5'd11, 32'h0,        32'h0,        2'b10, 1'b1, 2'd2, 1'b1, 32'h80000001, 1'b1, 5'd11, 32'h80000001};
    vecs[9]  = '{2'b01, 1'b1, 5'd12, 32'h0,        32'h0,        2'b00, 1'b0, 2'd3, 1'b1, 32'h8765F0A5, 1'b1, 5'd12, 32'h00000087};
    vecs[10] = '{2'b01, 1'b1, 5'd13, 32'h0,        32'h0,        2'b11, 1'b1, 2'd0, 1'b1, 32'hF000000F, 1'b1, 5'd13, 32'hF000000F};
    vecs[11] = '{2'b00, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h0,        2'b00, 1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 5'd31, 32'hFFFFFFFF};

    idle_inputs();
    w_valid = 1'b0; w_sel = 2'b11; w_we = 1'b0; w_rd = '0; w_alu = '0; w_pc = '0;
    w_size = '0; w_signed = 1'b0; w_lo = '0; w_rvalid = 1'b0; w_rdata = '0;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_we",    64'(gpr_we),    64'd0);
    chk("rst_waddr", 64'(gpr_waddr), 64'd0);
    chk("rst_wdata", 64'(gpr_wdata), 64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_ready", 64'(in_ready),  64'd1);
    rst_n = 1'b1;
    tick();

    // Back-to-back single-cycle ops from the table
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_sel = vecs[i].sel; in_we = vecs[i].we; in_rd = vecs[i].rd;
      in_alu = vecs[i].alu; in_pc = vecs[i].pc; in_mem_size = vecs[i].size;
      in_mem_signed = vecs[i].sgn; in_addr_lo = vecs[i].lo;
      mem_rvalid = vecs[i].rvalid; mem_rdata = vecs[i].rdata;
      tick();
      chk($sformatf("vec%0d_we", i),    64'(gpr_we),    64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_waddr", i), 64'(gpr_waddr), 64'(vecs[i].exp_waddr));
      chk($sformatf("vec%0d_wdata", i), 64'(gpr_wdata), 64'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_ready", i), 64'(in_ready),  64'd1);
    end
    idle_inputs();
    tick();
    chk("idle_we_drop", 64'(gpr_we), 64'd0);
    chk("idle_hold_waddr", 64'(gpr_waddr), 64'd31);

    // mem_rvalid with no MEM op in IDLE is ignored
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    chk("stray_rvalid_we",   64'(gpr_we),    64'd0);
    chk("stray_rvalid_busy", 64'(busy),      64'd0);
    chk("stray_rvalid_data", 64'(gpr_wdata), 64'hFFFFFFFF);

    // Stalled loads
    stalled_load(5'd4, 2'b00, 1'b1, 2'd1, 32'hBAADC0DE, 32'hFFFFFFC0, "stall_byte");
    stalled_load(5'd5, 2'b01, 1'b0, 2'd2, 32'hBAADC0DE, 32'h0000BAAD, "stall_half");

    // Reset while waiting abandons the load
    idle_inputs();
    in_valid = 1'b1; in_sel = 2'b01; in_we = 1'b1; in_rd = 5'd9;
    in_mem_size = 2'b10;
    tick();
    idle_inputs();
    chk("rstw_busy_pre", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("rstw_busy",  64'(busy),     64'd0);
    chk("rstw_ready", 64'(in_ready), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = 32'h13572468;
    tick();
    mem_rvalid = 1'b0;
    chk("rstw_no_we", 64'(gpr_we),    64'd0);
    chk("rstw_wdata", 64'(gpr_wdata), 64'd0);
    chk("rstw_ready_after", 64'(in_ready), 64'd1);

    // 64-bit datapath
    w_valid = 1'b1; w_sel = 2'b01; w_we = 1'b1; w_rd = 5'd7; w_size = 2'b11; w_signed = 1'b1;
    w_lo = 3'd0; w_rvalid = 1'b1; w_rdata = 64'h0123456789ABCDEF;
    tick();
    chk("w64_full_we",    64'(w_gpr_we), 64'd1);
    chk("w64_full_wdata", w_wdata,       64'h0123456789ABCDEF);
    w_rd = 5'd8; w_size = 2'b10; w_signed = 1'b1; w_lo = 3'd4;
    tick();
    chk("w64_word_waddr", 64'(w_waddr), 64'd8);
    chk("w64_word_wdata", w_wdata,      64'h0000000001234567);
    w_rd = 5'd9; w_size = 2'b10; w_signed = 1'b1; w_lo = 3'd1;
    tick();
    chk("w64_word_lo_sext", w_wdata, 64'hFFFFFFFF89ABCDEF);
    w_rd = 5'd10; w_size = 2'b01; w_signed = 1'b0; w_lo = 3'd7;
    tick();
    chk("w64_half_hi", w_wdata, 64'h0000000000000123);
    w_sel = 2'b10; w_rd = 5'd11; w_pc = 64'hFFFFFFFFFFFFFFFD; w_rvalid = 1'b0;
    tick();
    chk("w64_link_wrap", w_wdata, 64'h0000000000000001);
    w_valid = 1'b0;
    tick();
    chk("w64_we_drop", 64'(w_gpr_we), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
